el2_lsu_dccm_mem_ctl: RTL and testbench
=======================================

Name: el2_lsu_dccm_mem_ctl

Overview:
Parametrised successor to the DCCM banked memory. It adds configurable bank count, depth and data width, and an on-chip init engine that writes INIT_VALUE to every entry after reset or on request. It handles read/write bank conflicts with a one-entry read hold register and a ready handshake. It sits between the LSU DCCM control logic and the per-bank RAM arrays, which are behavioural arrays inside this block.

Parameters:
NUM_BANKS, 4, number of banks; power of 2, at least 2.
DATA_WIDTH, 39, bits per bank word (32 data + 7 ECC).
BYTE_WIDTH, 4, bytes per bank word; WIDTH_BITS = log2(BYTE_WIDTH).
INDEX_DEPTH, 1024, entries per bank; need not be a power of 2 (e.g. 3072).
INIT_VALUE, 0, DATA_WIDTH-bit value written by the init engine.
Derived: BANK_BITS = log2(NUM_BANKS); INDEX_BITS = ceil(log2(INDEX_DEPTH)); ADDR_BITS = WIDTH_BITS + BANK_BITS + INDEX_BITS.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
init_req  in  1  pulse; re-initialise all banks
wren  in  1  write request
rden  in  1  read request
wr_addr_lo  in  ADDR_BITS  write byte address, low word
wr_addr_hi  in  ADDR_BITS  write byte address, high word (unaligned)
rd_addr_lo  in  ADDR_BITS  read byte address, low word
rd_addr_hi  in  ADDR_BITS  read byte address, high word
wr_data_lo  in  DATA_WIDTH  write data for lo bank
wr_data_hi  in  DATA_WIDTH  write data for hi bank
req_ready  out  1  requests accepted this cycle
rd_valid  out  1  rd_data valid pulse
rd_data_lo  out  DATA_WIDTH  read data, lo address
rd_data_hi  out  DATA_WIDTH  read data, hi address
init_busy  out  1  init engine running
init_done  out  1  memory initialised, normal operation

Behaviour:
- Address decode: bank = addr[WIDTH_BITS +: BANK_BITS]; index = addr[WIDTH_BITS+BANK_BITS +: INDEX_BITS].
- Unaligned access: lo and hi bank fields differ, so two banks are accessed. Otherwise it is a single-bank access using lo.
- Out-of-range access (index >= INDEX_DEPTH): write is dropped; read returns all-zero for that half.
- FSM states:
  - INIT: one index per cycle (idx 0..INDEX_DEPTH-1), all banks written with INIT_VALUE in parallel. After idx == INDEX_DEPTH-1 is written, go to IDLE.
  - IDLE: normal operation.
- Reset: state=INIT, idx=0, hold empty, init_busy=1, init_done=0, req_ready=0, rd_valid=0, rd_data_lo/hi=0. Array contents are not reset.
- Init timing: exactly INDEX_DEPTH cycles after the rst deassert cycle, then init_done=1 and init_busy=0 from the first IDLE cycle.
- rst asserted during INIT restarts init from idx 0.
- init_req is honoured only in IDLE with hold empty. A request accepted in the same cycle completes first, and INIT begins the next cycle (init_done falls then). init_req at any other time is ignored.
- req_ready = (state==IDLE) & hold empty (combinational). wren/rden are ignored when req_ready=0.
- Read latency 1: rden accepted in cycle N gives rd_valid=1 in N+1, with data selected by the registered bank fields. rd_data holds its last value until the next rd_valid.
- Write takes effect at the cycle-N edge. A read accepted in N+1 to the same location returns the new data.
- Conflict: wren and rden accepted in the same cycle and any bank is common to both bank sets.
  - Write executes in N; the read address is captured in the hold register.
  - req_ready=0 in N+1; the held read executes in N+1; rd_valid in N+2.
  - With no common bank, both execute in N and rd_valid is in N+1.
- Unaligned write: the hi bank takes wr_data_hi at the hi index; the lo bank takes wr_data_lo at the lo index.
- Per-bank enable (for gating) = write-hit | read-hit | init-active.

Test Plan:
- Defaults. Release rst; hold rden. Expect req_ready=0 for 1024 cycles, init_done=1 at cycle 1024; read 0x0000 and 0x3FFC -> rd_data_lo=0.
- After init: write wr_addr_lo=hi=0x0004 data 0x12345678. Next cycle read 0x0004 -> rd_valid one cycle later, rd_data_lo=0x12345678.
- Unaligned write lo=0x000C (bank3 idx0) data 0xA, hi=0x0010 (bank0 idx1) data 0xB. Read lo=0x000C, hi=0x0010 -> rd_data_lo=0xA, rd_data_hi=0xB.
- Same cycle: write 0x0004 data 0x55 and read 0x0014 (both bank1) -> req_ready=0 in N+1, rd_valid in N+2. Same cycle write 0x0004 and read 0x0008 (bank2) -> rd_valid in N+1.
- init_req in IDLE after writes -> init_busy for 1024 cycles; then read 0x0004 -> 0. Assert rst at idx 500 -> init restarts and completes 1024 cycles after release.
- INDEX_DEPTH=3072: init takes 3072 cycles. Write to index 3072 is dropped; read of index 3072 returns 0.

Source files
------------

// File: rtl/el2_lsu_dccm_mem_ctl.sv
// Banked DCCM array with init engine, bank-conflict read hold and ready handshake.
// Per-bank RAMs are behavioural arrays held inside this block.
module el2_lsu_dccm_mem_ctl #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_WIDTH = 39,
    parameter int BYTE_WIDTH = 4,
    parameter int INDEX_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int WIDTH_BITS = $clog2(BYTE_WIDTH),
    localparam int BANK_BITS = $clog2(NUM_BANKS),
    localparam int INDEX_BITS = $clog2(INDEX_DEPTH),
    localparam int ADDR_BITS = WIDTH_BITS + BANK_BITS + INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [ADDR_BITS-1:0]  wr_addr_lo,
    input  logic [ADDR_BITS-1:0]  wr_addr_hi,
    input  logic [ADDR_BITS-1:0]  rd_addr_lo,
    input  logic [ADDR_BITS-1:0]  rd_addr_hi,
    input  logic [DATA_WIDTH-1:0] wr_data_lo,
    input  logic [DATA_WIDTH-1:0] wr_data_hi,
    output logic                  req_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_lo,
    output logic [DATA_WIDTH-1:0] rd_data_hi,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;
    localparam int IDX_LSB = WIDTH_BITS + BANK_BITS;
    localparam logic [INDEX_BITS:0] DEPTH = (INDEX_BITS + 1)'(INDEX_DEPTH);
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(INDEX_DEPTH - 1);

    typedef logic [BANK_BITS-1:0]  bank_t;
    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_BITS-1:0]  addr_t;

    function automatic bank_t bank_of(input addr_t a);
        return a[WIDTH_BITS +: BANK_BITS];
    endfunction

    function automatic idx_t idx_of(input addr_t a);
        return a[IDX_LSB +: INDEX_BITS];
    endfunction

    function automatic logic in_range(input idx_t i);
        return {1'b0, i} < DEPTH;
    endfunction

    word_t mem [NUM_BANKS][INDEX_DEPTH];

    logic [0:0] state;
    idx_t       init_idx;
    logic       hold_valid;
    addr_t      hold_lo;
    addr_t      hold_hi;

    logic  init_active;
    logic  wr_acc;
    logic  rd_acc;
    logic  conflict;
    logic  rd_exec;
    addr_t rs_lo;
    addr_t rs_hi;

    bank_t wb_lo, wb_hi, rb_lo, rb_hi;
    idx_t  wi_lo, wi_hi, ri_lo, ri_hi;
    logic  w_unal, w_lo_ok, w_hi_ok;
    logic  r_unal, r_lo_ok, r_hi_ok;

    logic [NUM_BANKS-1:0] wr_mask;
    logic [NUM_BANKS-1:0] rd_mask;
    logic [NUM_BANKS-1:0] wr_hit;
    logic [NUM_BANKS-1:0] rd_hit;
    logic [NUM_BANKS-1:0] bank_en;
    idx_t                 wr_idx [NUM_BANKS];
    word_t                wr_dat [NUM_BANKS];

    word_t rd_word_lo;
    word_t rd_word_hi;
    logic  unused_addr_bits;

    assign init_busy   = state == ST_INIT;
    assign init_done   = state == ST_IDLE;
    assign req_ready   = init_done & ~hold_valid;
    assign init_active = init_busy & ~rst;

    assign wr_acc = wren & req_ready;
    assign rd_acc = rden & req_ready;

    // A held read replays its captured addresses through the normal read path.
    assign rs_lo = hold_valid ? hold_lo : rd_addr_lo;
    assign rs_hi = hold_valid ? hold_hi : rd_addr_hi;

    assign wb_lo   = bank_of(wr_addr_lo);
    assign wb_hi   = bank_of(wr_addr_hi);
    assign wi_lo   = idx_of(wr_addr_lo);
    assign wi_hi   = idx_of(wr_addr_hi);
    assign w_unal  = wb_lo != wb_hi;
    assign w_lo_ok = in_range(wi_lo);
    assign w_hi_ok = in_range(wi_hi);

    assign rb_lo   = bank_of(rs_lo);
    assign rb_hi   = bank_of(rs_hi);
    assign ri_lo   = idx_of(rs_lo);
    assign ri_hi   = idx_of(rs_hi);
    assign r_unal  = rb_lo != rb_hi;
    assign r_lo_ok = in_range(ri_lo);
    assign r_hi_ok = in_range(ri_hi);

    always_comb begin
        wr_mask = '0;
        rd_mask = '0;
        wr_hit  = '0;
        rd_hit  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            logic use_hi;
            logic ok;
            use_hi     = w_unal & (wb_hi == bank_t'(b));
            ok         = use_hi ? w_hi_ok : w_lo_ok;
            wr_idx[b]  = use_hi ? wi_hi : wi_lo;
            wr_dat[b]  = use_hi ? wr_data_hi : wr_data_lo;
            wr_mask[b] = (wb_lo == bank_t'(b)) | (wb_hi == bank_t'(b));
            rd_mask[b] = (rb_lo == bank_t'(b)) | (rb_hi == bank_t'(b));
            wr_hit[b]  = wr_acc & wr_mask[b] & ok;
        end
        conflict = wr_acc & rd_acc & |(wr_mask & rd_mask);
        rd_exec  = hold_valid | (rd_acc & ~conflict);
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_hit[b] = rd_exec & rd_mask[b];
        end
    end

    assign bank_en = wr_hit | rd_hit | {NUM_BANKS{init_active}};

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b]) begin
                if (init_active) begin
                    mem[b][init_idx] <= INIT_VALUE;
                end else if (wr_hit[b]) begin
                    mem[b][wr_idx[b]] <= wr_dat[b];
                end
            end
        end
    end

    // Aligned reads touch one bank, so hi simply mirrors lo.
    assign rd_word_lo = r_lo_ok ? mem[rb_lo][ri_lo] : '0;
    assign rd_word_hi = !r_unal ? rd_word_lo :
                        r_hi_ok ? mem[rb_hi][ri_hi] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_idx   <= '0;
            hold_valid <= 1'b0;
            hold_lo    <= '0;
            hold_hi    <= '0;
            rd_valid   <= 1'b0;
            rd_data_lo <= '0;
            rd_data_hi <= '0;
        end else begin
            rd_valid <= rd_exec;
            if (rd_exec) begin
                rd_data_lo <= rd_word_lo;
                rd_data_hi <= rd_word_hi;
            end
            if (hold_valid) begin
                hold_valid <= 1'b0;
            end else if (conflict) begin
                hold_valid <= 1'b1;
                hold_lo    <= rd_addr_lo;
                hold_hi    <= rd_addr_hi;
            end
            unique case (1'b1)
                (state == ST_INIT): begin
                    init_idx <= init_idx + INDEX_BITS'(1);
                    if (init_idx == LAST_IDX) begin
                        state    <= ST_IDLE;
                        init_idx <= '0;
                    end
                end
                (state == ST_IDLE): begin
                    if (init_req && !hold_valid) begin
                        state    <= ST_INIT;
                        init_idx <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign unused_addr_bits = ^{wr_addr_lo[WIDTH_BITS-1:0],
                                wr_addr_hi[WIDTH_BITS-1:0],
                                rd_addr_lo[WIDTH_BITS-1:0],
                                rd_addr_hi[WIDTH_BITS-1:0]};

endmodule

// File: tb/tb_el2_lsu_dccm_mem_ctl.sv
// Scoreboard bench for el2_lsu_dccm_mem_ctl: default geometry plus a
// 3072-deep instance with a non-zero init value.
module tb_el2_lsu_dccm_mem_ctl;

    localparam logic [38:0] INIT_B = 39'h5A_A5A5_A5A5;

    typedef struct {
        int          cyc;
        logic [63:0] lo;
        logic [63:0] hi;
        bit          chk_hi;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic        rst, init_req, wren, rden;
    logic [13:0] wr_addr_lo, wr_addr_hi, rd_addr_lo, rd_addr_hi;
    logic [38:0] wr_data_lo, wr_data_hi;
    logic        req_ready, rd_valid, init_busy, init_done;
    logic [38:0] rd_data_lo, rd_data_hi;

    logic        rst_b, init_req_b, wren_b, rden_b;
    logic [15:0] wr_addr_lo_b, wr_addr_hi_b, rd_addr_lo_b, rd_addr_hi_b;
    logic [38:0] wr_data_lo_b, wr_data_hi_b;
    logic        req_ready_b, rd_valid_b, init_busy_b, init_done_b;
    logic [38:0] rd_data_lo_b, rd_data_hi_b;

    el2_lsu_dccm_mem_ctl u_dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .wren(wren), .rden(rden),
        .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi),
        .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
        .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
        .req_ready(req_ready), .rd_valid(rd_valid),
        .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi),
        .init_busy(init_busy), .init_done(init_done)
    );

    el2_lsu_dccm_mem_ctl #(
        .INDEX_DEPTH(3072),
        .INIT_VALUE(INIT_B)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .init_req(init_req_b),
        .wren(wren_b), .rden(rden_b),
        .wr_addr_lo(wr_addr_lo_b), .wr_addr_hi(wr_addr_hi_b),
        .rd_addr_lo(rd_addr_lo_b), .rd_addr_hi(rd_addr_hi_b),
        .wr_data_lo(wr_data_lo_b), .wr_data_hi(wr_data_hi_b),
        .req_ready(req_ready_b), .rd_valid(rd_valid_b),
        .rd_data_lo(rd_data_lo_b), .rd_data_hi(rd_data_hi_b),
        .init_busy(init_busy_b), .init_done(init_done_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic we, input logic re, input logic ir,
                           input logic [13:0] wlo, input logic [13:0] whi,
                           input logic [38:0] dlo, input logic [38:0] dhi,
                           input logic [13:0] rlo, input logic [13:0] rhi,
                           input int lat, input logic [38:0] elo,
                           input logic [38:0] ehi, input bit chi);
        wren = we; rden = re; init_req = ir;
        wr_addr_lo = wlo; wr_addr_hi = whi;
        wr_data_lo = dlo; wr_data_hi = dhi;
        rd_addr_lo = rlo; rd_addr_hi = rhi;
        if (re) qa.push_back('{cyc + lat, 64'(elo), 64'(ehi), chi});
        step();
        wren = 1'b0; rden = 1'b0; init_req = 1'b0;
    endtask

    task automatic issue_b(input logic we, input logic re,
                           input logic [15:0] wlo, input logic [38:0] dlo,
                           input logic [15:0] rlo, input logic [15:0] rhi,
                           input logic [38:0] elo, input logic [38:0] ehi);
        wren_b = we; rden_b = re;
        wr_addr_lo_b = wlo; wr_addr_hi_b = wlo;
        wr_data_lo_b = dlo; wr_data_hi_b = dlo;
        rd_addr_lo_b = rlo; rd_addr_hi_b = rhi;
        if (re) qb.push_back('{cyc + 1, 64'(elo), 64'(ehi), 1'b1});
        step();
        wren_b = 1'b0; rden_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (qa.size() == 0) begin
                check("a_rd_expected", 64'(rd_valid), 64'(0));
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_rd_cycle", 64'(cyc), 64'(e.cyc));
                check("a_rd_lo", 64'(rd_data_lo), e.lo);
                if (e.chk_hi) check("a_rd_hi", 64'(rd_data_hi), e.hi);
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid_b) begin
            if (qb.size() == 0) begin
                check("b_rd_expected", 64'(rd_valid_b), 64'(0));
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_rd_cycle", 64'(cyc), 64'(e.cyc));
                check("b_rd_lo", 64'(rd_data_lo_b), e.lo);
                if (e.chk_hi) check("b_rd_hi", 64'(rd_data_hi_b), e.hi);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        rst = 1'b1; init_req = 1'b0; wren = 1'b0; rden = 1'b1;
        wr_addr_lo = '0; wr_addr_hi = '0; rd_addr_lo = '0; rd_addr_hi = '0;
        wr_data_lo = '0; wr_data_hi = '0;
        rst_b = 1'b1; init_req_b = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
        wr_addr_lo_b = '0; wr_addr_hi_b = '0;
        rd_addr_lo_b = '0; rd_addr_hi_b = '0;
        wr_data_lo_b = '0; wr_data_hi_b = '0;
        repeat (3) step();

        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_init_busy", 64'(init_busy), 64'(1));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_lo", 64'(rd_data_lo), 64'(0));
        check("rst_rd_hi", 64'(rd_data_hi), 64'(0));

        // Power-up init with rden held high throughout.
        rst = 1'b0;
        n = 0; bad = 1'b0;
        while (!init_done && n < 5000) begin
            step();
            n++;
            if (!init_done && req_ready) bad = 1'b1;
        end
        rden = 1'b0;
        check("init_cycles", 64'(n), 64'(1024));
        check("ready_during_init", 64'(bad), 64'(0));
        check("init_busy_clear", 64'(init_busy), 64'(0));
        check("ready_after_init", 64'(req_ready), 64'(1));

        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 1, 0, 0, 0);
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h3FFC, 14'h3FFC, 1, 0, 0, 0);

        issue_a(1, 0, 0, 14'h0004, 14'h0004, 39'h12345678, 39'h12345678,
                0, 0, 0, 0, 0, 0);
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h0004, 14'h0004,
                1, 39'h12345678, 0, 0);
        step();
        check("rd_valid_pulse", 64'(rd_valid), 64'(0));
        check("rd_data_hold", 64'(rd_data_lo), 64'h12345678);

        issue_a(1, 0, 0, 14'h000C, 14'h0010, 39'hA, 39'hB,
                0, 0, 0, 0, 0, 0);
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h000C, 14'h0010, 1, 39'hA, 39'hB, 1);

        // Same-bank write/read pairs go through the hold register.
        issue_a(1, 1, 0, 14'h0004, 14'h0004, 39'h55, 39'h55,
                14'h0014, 14'h0014, 2, 0, 0, 0);
        check("conflict1_ready", 64'(req_ready), 64'(0));
        step();
        check("conflict1_ready_back", 64'(req_ready), 64'(1));
        issue_a(1, 1, 0, 14'h0004, 14'h0004, 39'h66, 39'h66,
                14'h0004, 14'h0004, 2, 39'h66, 0, 0);
        check("conflict2_ready", 64'(req_ready), 64'(0));
        step();
        issue_a(1, 1, 0, 14'h000C, 14'h0010, 39'hC, 39'hD,
                14'h0020, 14'h0020, 2, 0, 0, 0);
        check("conflict_hi_ready", 64'(req_ready), 64'(0));
        step();
        issue_a(1, 1, 0, 14'h0004, 14'h0004, 39'h77, 39'h77,
                14'h0008, 14'h0008, 1, 0, 0, 0);
        check("noconflict_ready", 64'(req_ready), 64'(1));
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h000C, 14'h0010, 1, 39'hC, 39'hD, 1);

        // init_req with a read in the same cycle: the read completes first.
        issue_a(0, 1, 1, 0, 0, 0, 0, 14'h0004, 14'h0004, 1, 39'h77, 0, 0);
        check("reinit_busy", 64'(init_busy), 64'(1));
        check("reinit_done_low", 64'(init_done), 64'(0));
        check("reinit_ready", 64'(req_ready), 64'(0));
        n = 0;
        while (!init_done && n < 5000) begin
            step();
            n++;
        end
        check("reinit_cycles", 64'(n), 64'(1024));
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h0004, 14'h0004, 1, 0, 0, 0);
        issue_a(0, 1, 0, 0, 0, 0, 0, 14'h000C, 14'h0010, 1, 0, 0, 1);
        step();

        // Reset in the middle of a re-init restarts it from index 0.
        issue_a(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (500) step();
        check("mid_init_busy", 64'(init_busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 5000) begin
            step();
            n++;
        end
        check("restart_cycles", 64'(n), 64'(1024));

        rst_b = 1'b0;
        n = 0;
        while (!init_done_b && n < 8000) begin
            step();
            n++;
        end
        check("b_init_cycles", 64'(n), 64'(3072));
        issue_b(1, 0, 16'hC000, 39'h99, 0, 0, 0, 0);
        issue_b(1, 0, 16'hBFF0, 39'h44, 0, 0, 0, 0);
        issue_b(0, 1, 0, 0, 16'hC000, 16'hC000, 0, 0);
        issue_b(0, 1, 0, 0, 16'hBFF0, 16'hBFF0, 39'h44, 39'h44);
        issue_b(0, 1, 0, 0, 16'hBFFC, 16'hC000, INIT_B, 0);
        issue_b(0, 1, 0, 0, 16'hBFF4, 16'hBFF4, INIT_B, INIT_B);

        repeat (4) step();
        check("a_queue_drained", 64'(qa.size()), 64'(0));
        check("b_queue_drained", 64'(qb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
